vec_alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational vector ALU: LANES lanes of WIDTH-bit unsigned data. It has a registered result, per-lane overflow and divide-by-zero flags, an optional saturating mode, and a multi-cycle iterative divider. It sits between the vector register-file read stage and write-back, and stalls upstream through valid/ready while a division is in flight.

---
 rtl/vec_alu_pkg.sv | 23 ++
 rtl/vec_div_lane.sv | 53 +++++
 rtl/vec_alu_seq.sv | 151 +++++++++++++++
 tb/tb_vec_alu_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared opcode and state encodings for the sequential vector ALU.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MOV = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100,
    OP_DUP = 3'b111
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Opcodes 101 and 110 are reserved; executing one raises the illegal flag.
  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/vec_div_lane.sv
// One lane of the restoring divider: latched divisor, remainder and a
// quotient register that starts holding the dividend and shifts the
// quotient bits in MSB first.
module vec_div_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo_next,
  output logic             o_dz
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. A zero divisor always fits, which
  // yields an all-ones quotient.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_div});
    w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    o_quo_next = {r_quo[WIDTH-2:0], w_ge};
  end

  assign o_dz = (r_div == '0);

  // Operand latch on start, one quotient bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_rem_next;
      r_quo <= o_quo_next;
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Handshaked vector ALU: single-cycle lane ops, iterative divide, registered
// result held until the consumer takes it.
module vec_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int LANES = 16,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  A,
  input  logic [LANES-1:0][WIDTH-1:0]  B,
  input  logic [2:0]                   Operation,
  input  logic                         sat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  Result,
  output logic [LANES-1:0]             ovf,
  output logic [LANES-1:0]             dz,
  output logic                         illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CW-1:0]               r_cnt;
  logic                        w_accept;
  logic                        w_div_start;
  logic                        w_step;
  logic                        w_last;
  logic [LANES-1:0][WIDTH-1:0] w_res;
  logic [LANES-1:0]            w_ovf;
  logic [LANES-1:0][WIDTH-1:0] w_quo;
  logic [LANES-1:0]            w_dz;

  assign w_accept    = in_valid && in_ready;
  assign w_div_start = w_accept && (Operation == OP_DIV);
  assign w_last      = w_step && (r_cnt == CW'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_dif;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_lres;
    logic                 w_lovf;

    assign w_sum  = {1'b0, A[g]} + {1'b0, B[g]};
    assign w_dif  = {1'b0, A[g]} - {1'b0, B[g]};
    assign w_prod = {{WIDTH{1'b0}}, A[g]} * {{WIDTH{1'b0}}, B[g]};

    // Single-cycle lane function; DIV and reserved opcodes give zero here.
    always_comb begin
      w_lres = '0;
      w_lovf = 1'b0;
      case (Operation)
        OP_ADD: begin
          w_lovf = w_sum[WIDTH];
          w_lres = (sat && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
        end
        OP_SUB: begin
          w_lovf = w_dif[WIDTH];
          w_lres = (sat && w_dif[WIDTH]) ? '0 : w_dif[WIDTH-1:0];
        end
        OP_MOV: w_lres = B[g];
        OP_MUL: begin
          w_lovf = |w_prod[2*WIDTH-1:WIDTH];
          w_lres = w_prod[WIDTH-1:0];
        end
        OP_DUP: w_lres = A[g/2];
        default: ;
      endcase
    end

    assign w_res[g] = w_lres;
    assign w_ovf[g] = w_lovf;

    vec_div_lane #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst_n      (reset),
      .i_start    (w_div_start),
      .i_step     (w_step),
      .i_dividend (A[g]),
      .i_divisor  (B[g]),
      .o_quo_next (w_quo[g]),
      .o_dz       (w_dz[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, input handshake and divider step strobe.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = reset && (!out_valid || out_ready);
        if (in_valid && in_ready && (Operation == OP_DIV)) w_state_next = BUSY;
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Quotient-bit counter: loaded on DIV accept, counts down while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_cnt <= '0;
    else if (w_div_start) r_cnt <= CW'(WIDTH);
    else if (w_step)      r_cnt <= r_cnt - CW'(1);
  end

  // Output register: loads on a non-DIV accept or the final divide step,
  // otherwise holds until drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result    <= '0;
      ovf       <= '0;
      dz        <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_accept && !w_div_start) begin
      Result    <= w_res;
      ovf       <= w_ovf;
      dz        <= '0;
      illegal   <= is_reserved(Operation);
      out_valid <= 1'b1;
    end else if (w_div_start) begin
      out_valid <= 1'b0;
    end else if (w_last) begin
      Result    <= w_quo;
      ovf       <= '0;
      dz        <= w_dz;
      illegal   <= 1'b0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq against an arithmetic reference model.
module tb_vec_alu_seq;

  localparam int L = 16;
  localparam int W = 16;
  typedef logic [L-1:0][W-1:0] vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  vec_t           A, B;
  logic [2:0]     Operation;
  logic           sat;
  logic           out_valid;
  logic           out_ready;
  vec_t           Result;
  logic [L-1:0]   ovf, dz;
  logic           illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.LANES(L), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ovf       (ovf),
    .dz        (dz),
    .illegal   (illegal)
  );

  // Reference model from the opcode definitions using plain integer math.
  function automatic void model(input logic [2:0] op, input logic s, input vec_t a, input vec_t b,
                                output vec_t r, output logic [L-1:0] ov, output logic [L-1:0] dzv,
                                output logic il);
    longint m, x, y, p;
    m = longint'(1) << W;
    r = '0; ov = '0; dzv = '0; il = 1'b0;
    for (int j = 0; j < L; j++) begin
      x = longint'(a[j]);
      y = longint'(b[j]);
      case (op)
        3'd0: begin
          if (x + y >= m) begin ov[j] = 1'b1; r[j] = s ? W'(m - 1) : W'(x + y - m); end
          else r[j] = W'(x + y);
        end
        3'd1: begin
          if (x < y) begin ov[j] = 1'b1; r[j] = s ? '0 : W'(x - y + m); end
          else r[j] = W'(x - y);
        end
        3'd2: r[j] = b[j];
        3'd3: begin p = x * y; r[j] = W'(p % m); ov[j] = (p >= m); end
        3'd4: begin
          if (y == 0) begin r[j] = W'(m - 1); dzv[j] = 1'b1; end
          else r[j] = W'(x / y);
        end
        3'd7: r[j] = a[j / 2];
        default: il = 1'b1;
      endcase
    end
  endfunction

  task automatic rand_vec(output vec_t v);
    for (int j = 0; j < L; j++) v[j] = W'($urandom);
  endtask

  // Present one op, wait for accept, then wait for out_valid. Operands are
  // scrambled right after accept. Returns the edges from accept to result.
  task automatic exec(input logic [2:0] op, input logic s, input vec_t a, input vec_t b,
                      output bit ok, output int edges, output bit ready_seen);
    int n;
    vec_t junk;
    ok = 1'b0; edges = 0; ready_seen = 1'b0; n = 0;
    @(negedge clk);
    A = a; B = b; Operation = op; sat = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rand_vec(junk); A = junk;
    rand_vec(junk); B = junk;
    while (!out_valid && edges < 60) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; Operation = 3'd0; sat = 1'b0;
    A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || Result !== '0 || ovf !== '0 || dz !== '0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b Result=%h ovf=%h dz=%h illegal=%b, want all zero",
               in_ready, out_valid, Result, ovf, dz, illegal);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    rand_vec(a); rand_vec(b);
    a[0] = 16'd65535; b[0] = 16'd1; a[1] = 16'd200; b[1] = 16'd10;
    for (int s = 0; s < 2; s++) begin
      model(3'd0, s[0], a, b, er, eo, ed, ei);
      exec(3'd0, s[0], a, b, ok, e, rs);
      total++;
      if (!ok || e != 0) begin bad++; $display("FAIL add_latency: ok=%0d edges=%0d want edges 0", ok, e); end
      total++;
      if (Result[0] !== (s ? 16'd65535 : 16'd0) || ovf[0] !== 1'b1 || Result[1] !== 16'd210 || ovf[1] !== 1'b0) begin
        bad++;
        $display("FAIL add_lanes01 sat=%0d: r0=%0d ovf0=%b r1=%0d ovf1=%b want %0d,1,210,0",
                 s, Result[0], ovf[0], Result[1], ovf[1], s ? 65535 : 0);
      end
      total++;
      if (Result !== er || ovf !== eo || dz !== ed || illegal !== ei) begin
        bad++;
        $display("FAIL add_vector sat=%0d: got %h ovf=%h want %h ovf=%h", s, Result, ovf, er, eo);
      end
    end
  endtask

  task automatic test_sub;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    rand_vec(a); rand_vec(b);
    a[0] = 16'd100; b[0] = 16'd55; a[1] = 16'd5; b[1] = 16'd25;
    for (int s = 0; s < 2; s++) begin
      model(3'd1, s[0], a, b, er, eo, ed, ei);
      exec(3'd1, s[0], a, b, ok, e, rs);
      total++;
      if (!ok || Result[0] !== 16'd45 || ovf[0] !== 1'b0 || Result[1] !== (s ? 16'd0 : 16'd65516) || ovf[1] !== 1'b1) begin
        bad++;
        $display("FAIL sub_lanes01 sat=%0d: r0=%0d ovf0=%b r1=%0d ovf1=%b want 45,0,%0d,1",
                 s, Result[0], ovf[0], Result[1], ovf[1], s ? 0 : 65516);
      end
      total++;
      if (Result !== er || ovf !== eo || dz !== ed || illegal !== ei) begin
        bad++;
        $display("FAIL sub_vector sat=%0d: got %h ovf=%h want %h ovf=%h", s, Result, ovf, er, eo);
      end
    end
  endtask

  task automatic test_mul_mov_dup;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    rand_vec(a); rand_vec(b);
    a[0] = 16'd300; b[0] = 16'd300; a[1] = 16'd25; b[1] = 16'd2;
    model(3'd3, 1'b1, a, b, er, eo, ed, ei);
    exec(3'd3, 1'b1, a, b, ok, e, rs);
    total++;
    if (!ok || Result[0] !== 16'd24464 || ovf[0] !== 1'b1 || Result[1] !== 16'd50 || ovf[1] !== 1'b0) begin
      bad++;
      $display("FAIL mul_lanes01: r0=%0d ovf0=%b r1=%0d ovf1=%b want 24464,1,50,0", Result[0], ovf[0], Result[1], ovf[1]);
    end
    total++;
    if (Result !== er || ovf !== eo) begin bad++; $display("FAIL mul_vector: got %h ovf=%h want %h ovf=%h", Result, ovf, er, eo); end

    rand_vec(a); rand_vec(b);
    exec(3'd2, 1'b0, a, b, ok, e, rs);
    total++;
    if (!ok || Result !== b || ovf !== '0 || illegal !== 1'b0) begin
      bad++; $display("FAIL mov_vector: got %h ovf=%h want %h ovf=0", Result, ovf, b);
    end

    rand_vec(a); rand_vec(b);
    a[0] = 16'd2; a[1] = 16'd6; a[2] = 16'd10; a[3] = 16'd15;
    model(3'd7, 1'b0, a, b, er, eo, ed, ei);
    exec(3'd7, 1'b0, a, b, ok, e, rs);
    total++;
    if (!ok || Result[0] !== 16'd2 || Result[1] !== 16'd2 || Result[2] !== 16'd6 || Result[3] !== 16'd6 ||
        Result[4] !== 16'd10 || Result[5] !== 16'd10 || Result[6] !== 16'd15 || Result[7] !== 16'd15) begin
      bad++; $display("FAIL dup_lanes0to7: got %h want ...000f000f000a000a0006000600020002 in low lanes", Result);
    end
    total++;
    if (Result !== er || ovf !== '0) begin bad++; $display("FAIL dup_vector: got %h want %h", Result, er); end
  endtask

  task automatic test_div;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    rand_vec(a); rand_vec(b);
    a[0] = 16'd200; b[0] = 16'd100; a[1] = 16'd15; b[1] = 16'd2; a[2] = 16'd7; b[2] = 16'd0;
    model(3'd4, 1'b0, a, b, er, eo, ed, ei);
    exec(3'd4, 1'b0, a, b, ok, e, rs);
    total++;
    if (!ok || e != W) begin bad++; $display("FAIL div_latency: ok=%0d edges=%0d want %0d", ok, e, W); end
    total++;
    if (rs) begin bad++; $display("FAIL div_ready_low: in_ready seen 1 while busy, want 0"); end
    total++;
    if (Result[0] !== 16'd2 || Result[1] !== 16'd7 || Result[2] !== 16'hffff || dz[2] !== 1'b1 || dz[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL div_lanes012: r=%0d,%0d,%0d dz=%b want 2,7,65535 dz[2:0]=100", Result[0], Result[1], Result[2], dz[2:0]);
    end
    total++;
    if (Result !== er || dz !== ed || ovf !== '0 || illegal !== 1'b0) begin
      bad++; $display("FAIL div_vector: got %h dz=%h want %h dz=%h", Result, dz, er, ed);
    end
  endtask

  task automatic test_illegal;
    vec_t a, b; bit ok, rs; int e;
    for (int k = 5; k <= 6; k++) begin
      rand_vec(a); rand_vec(b);
      exec(3'(k), 1'b1, a, b, ok, e, rs);
      total++;
      if (!ok || Result !== '0 || illegal !== 1'b1 || ovf !== '0 || dz !== '0) begin
        bad++; $display("FAIL illegal_op%0d: Result=%h illegal=%b ovf=%h dz=%h want 0,1,0,0", k, Result, illegal, ovf, dz);
      end
    end
  endtask

  task automatic test_random;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    logic [2:0] op; logic s;
    for (int it = 0; it < 30; it++) begin
      op = 3'($urandom_range(0, 7));
      s  = 1'($urandom);
      rand_vec(a); rand_vec(b);
      for (int j = 0; j < L; j++) begin
        if ($urandom_range(0, 7) == 0) b[j] = '0;
        if ($urandom_range(0, 3) == 0) a[j] = W'($urandom_range(0, 300));
      end
      model(op, s, a, b, er, eo, ed, ei);
      exec(op, s, a, b, ok, e, rs);
      total++;
      if (!ok || e != ((op == 3'd4) ? W : 0) || Result !== er || ovf !== eo || dz !== ed || illegal !== ei) begin
        bad++;
        $display("FAIL random op=%0d sat=%0d: ok=%0d edges=%0d got %h ovf=%h dz=%h il=%b want %h ovf=%h dz=%h il=%b",
                 op, s, ok, e, Result, ovf, dz, illegal, er, eo, ed, ei);
      end
    end
  endtask

  task automatic test_backpressure;
    vec_t a, b, r1, r2; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    rand_vec(a); rand_vec(b);
    model(3'd0, 1'b0, a, b, r1, eo, ed, ei);
    exec(3'd0, 1'b0, a, b, ok, e, rs);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== r1) begin
        bad++;
        $display("FAIL backpressure_hold c=%0d: out_valid=%b in_ready=%b Result=%h want 1,0,%h", c, out_valid, in_ready, Result, r1);
      end
    end
    rand_vec(a); rand_vec(b);
    model(3'd0, 1'b1, a, b, r2, eo, ed, ei);
    A = a; B = b; Operation = 3'd0; sat = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_accept_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || Result !== r2 || ovf !== eo) begin
      bad++; $display("FAIL drain_accept_nobubble: out_valid=%b Result=%h want 1,%h", out_valid, Result, r2);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_final: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; logic [2:0] op; logic s;
    logic [2:0] ops [6];
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd5};
    out_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      op = ops[$urandom_range(0, 5)];
      s  = 1'($urandom);
      rand_vec(a); rand_vec(b);
      model(op, s, a, b, er, eo, ed, ei);
      A = a; B = b; Operation = op; sat = s; in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready it=%0d: got %b want 1", it, in_ready); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || Result !== er || ovf !== eo || illegal !== ei) begin
        bad++;
        $display("FAIL b2b_result it=%0d op=%0d: ov=%b got %h ovf=%h il=%b want %h ovf=%h il=%b",
                 it, op, out_valid, Result, ovf, illegal, er, eo, ei);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    vec_t a, b, er; logic [L-1:0] eo, ed; logic ei; bit ok, rs; int e, n;
    bit seen_valid;
    a = '0; b = '0;
    for (int j = 0; j < L; j++) begin a[j] = W'(j + 1000); b[j] = W'(j + 1); end
    exec(3'd0, 1'b0, a, b, ok, e, rs);
    rand_vec(a); rand_vec(b);
    @(negedge clk);
    A = a; B = b; Operation = 3'd4; sat = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL div_busy_before_reset: out_valid=%b in_ready=%b want 0,0", out_valid, in_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (Result !== '0 || ovf !== '0 || dz !== '0 || illegal !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_clear: Result=%h ovf=%h dz=%h il=%b ov=%b ir=%b want all 0",
               Result, ovf, dz, illegal, out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    seen_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen_valid = 1'b1; end
    total++;
    if (seen_valid) begin bad++; $display("FAIL aborted_div_output: out_valid seen 1 want 0"); end
    rand_vec(a); rand_vec(b);
    model(3'd0, 1'b0, a, b, er, eo, ed, ei);
    exec(3'd0, 1'b0, a, b, ok, e, rs);
    total++;
    if (!ok || e != 0 || Result !== er || ovf !== eo || dz !== '0 || illegal !== 1'b0) begin
      bad++; $display("FAIL post_reset_add: ok=%0d got %h ovf=%h want %h ovf=%h", ok, Result, ovf, er, eo);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mul_mov_dup;
    test_div;
    test_illegal;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
